// File: rtl/legv8_control_fsm.sv
// Multi-cycle LEGv8 control unit: FETCH latches the ROM word, EXEC/MEM emit the datapath control word.
// Optional B.cond decode is enabled by defining LEGV8_CTRL_BCOND_EN.
module legv8_control_fsm #(
    parameter int CW_W = 30,
    parameter int ST_W = 3
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [31:0]     instruction,
    input  logic [4:0]      status,
    output logic [CW_W-1:0] control_word,
    output logic [63:0]     constant,
    output logic [ST_W-1:0] state,
    output logic            illegal
);
    localparam logic [ST_W-1:0] S_FETCH = 3'd0;
    localparam logic [ST_W-1:0] S_EXEC  = 3'd1;
    localparam logic [ST_W-1:0] S_MEM   = 3'd2;
    localparam logic [ST_W-1:0] S_HALT  = 3'd3;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_SUBS = 11'b11101011000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [9:0]  OP_ADDI = 10'b1001000100;
    localparam logic [9:0]  OP_SUBI = 10'b1101000100;
    localparam logic [5:0]  OP_B    = 6'b000101;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;
    localparam logic [7:0]  OP_CBNZ = 8'b10110101;

    localparam logic [4:0] FS_AND = 5'b00000;
    localparam logic [4:0] FS_ORR = 5'b00100;
    localparam logic [4:0] FS_ADD = 5'b01000;
    localparam logic [4:0] FS_SUB = 5'b01001;
    localparam logic [4:0] XZR    = 5'd31;

    logic [ST_W-1:0] r_state;
    logic [31:0]     r_ir;

    logic [ST_W-1:0] w_next;
    logic [10:0]     w_op11;
    logic [9:0]      w_op10;
    logic [7:0]      w_op8;
    logic [5:0]      w_op6;
    logic [4:0]      w_rd, w_rn, w_rm, w_rfs;
    logic [63:0]     w_dimm, w_bimm, w_cbimm, w_const;
    logic            w_en_pc, w_en_mem, w_en_alu, w_pcsel, w_bsel, w_sl, w_wm, w_wr;
    logic [1:0]      w_ps;
    logic [4:0]      w_fs, w_sb, w_sa, w_da;
    logic [CW_W-1:0] w_cw;
    logic            w_cond;

    assign w_op11 = r_ir[31:21];
    assign w_op10 = r_ir[31:22];
    assign w_op8  = r_ir[31:24];
    assign w_op6  = r_ir[31:26];
    assign w_rd   = r_ir[4:0];
    assign w_rn   = r_ir[9:5];
    assign w_rm   = r_ir[20:16];
    assign w_rfs  = (w_op11 == OP_ADD) ? FS_ADD :
                    (w_op11 == OP_AND) ? FS_AND :
                    (w_op11 == OP_ORR) ? FS_ORR : FS_SUB;

    // Branch offsets are pre-decremented because FETCH has already advanced the PC by 4.
    assign w_dimm  = {{55{r_ir[20]}}, r_ir[20:12]};
    assign w_bimm  = {{38{r_ir[25]}}, r_ir[25:0]} - 64'd1;
    assign w_cbimm = {{45{r_ir[23]}}, r_ir[23:5]} - 64'd1;

`ifdef LEGV8_CTRL_BCOND_EN
    // status[4:1] = {V,C,N,Z}
    always_comb begin
        w_cond = 1'b0;
        case (r_ir[3:0])
            4'h0: w_cond = status[1];
            4'h1: w_cond = !status[1];
            4'h2: w_cond = status[3];
            4'h3: w_cond = !status[3];
            4'h4: w_cond = status[2];
            4'h5: w_cond = !status[2];
            4'h6: w_cond = status[4];
            4'h7: w_cond = !status[4];
            4'h8: w_cond = status[3] && !status[1];
            4'h9: w_cond = !(status[3] && !status[1]);
            4'hA: w_cond = (status[2] == status[4]);
            4'hB: w_cond = (status[2] != status[4]);
            4'hC: w_cond = !status[1] && (status[2] == status[4]);
            4'hD: w_cond = !(!status[1] && (status[2] == status[4]));
            4'hE: w_cond = 1'b1;
            default: w_cond = 1'b0;
        endcase
    end
`else
    logic w_unused_flags;
    assign w_unused_flags = ^status[4:1];
    assign w_cond = 1'b0;
`endif

    always_comb begin
        w_next   = r_state;
        w_en_pc  = 1'b0;
        w_en_mem = 1'b0;
        w_en_alu = 1'b0;
        w_pcsel  = 1'b0;
        w_bsel   = 1'b0;
        w_sl     = 1'b0;
        w_wm     = 1'b0;
        w_wr     = 1'b0;
        w_ps     = 2'b00;
        w_fs     = FS_AND;
        w_sb     = XZR;
        w_sa     = XZR;
        w_da     = XZR;
        w_const  = 64'd0;
        case (r_state)
            S_FETCH: begin
                w_ps   = 2'b01;
                w_next = S_EXEC;
            end
            S_EXEC: begin
                w_next = S_FETCH;
                case (w_op11)
                    OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_SUBS: begin
                        w_en_alu = 1'b1;
                        w_wr     = 1'b1;
                        w_sl     = (w_op11 == OP_SUBS);
                        w_fs     = w_rfs;
                        w_da     = w_rd;
                        w_sa     = w_rn;
                        w_sb     = w_rm;
                    end
                    OP_LDUR: begin
                        w_bsel  = 1'b1;
                        w_const = w_dimm;
                        w_fs    = FS_ADD;
                        w_sa    = w_rn;
                        w_next  = S_MEM;
                    end
                    OP_STUR: begin
                        w_bsel  = 1'b1;
                        w_const = w_dimm;
                        w_fs    = FS_ADD;
                        w_sa    = w_rn;
                        w_sb    = w_rd;
                        w_wm    = 1'b1;
                    end
                    default: begin
                        if (w_op10 == OP_ADDI || w_op10 == OP_SUBI) begin
                            w_en_alu = 1'b1;
                            w_wr     = 1'b1;
                            w_bsel   = 1'b1;
                            w_const  = {52'd0, r_ir[21:10]};
                            w_fs     = (w_op10 == OP_ADDI) ? FS_ADD : FS_SUB;
                            w_da     = w_rd;
                            w_sa     = w_rn;
                        end else if (w_op6 == OP_B) begin
                            w_pcsel = 1'b1;
                            w_ps    = 2'b11;
                            w_const = w_bimm;
                        end else if (w_op8 == OP_CBZ || w_op8 == OP_CBNZ) begin
                            w_pcsel = 1'b1;
                            w_const = w_cbimm;
                            w_fs    = FS_ORR;
                            w_sa    = w_rd;
                            w_ps    = ((w_op8 == OP_CBZ) == status[0]) ? 2'b11 : 2'b00;
                        end
`ifdef LEGV8_CTRL_BCOND_EN
                        else if (w_op8 == 8'b01010100) begin
                            w_pcsel = 1'b1;
                            w_const = w_cbimm;
                            w_ps    = w_cond ? 2'b11 : 2'b00;
                        end
`endif
                        else begin
                            w_sb   = 5'd0;
                            w_sa   = 5'd0;
                            w_da   = 5'd0;
                            w_next = S_HALT;
                        end
                    end
                endcase
            end
            S_MEM: begin
                w_en_mem = 1'b1;
                w_wr     = 1'b1;
                w_bsel   = 1'b1;
                w_const  = w_dimm;
                w_fs     = FS_ADD;
                w_sa     = w_rn;
                w_da     = w_rd;
                w_next   = S_FETCH;
            end
            S_HALT: begin
                w_sb = 5'd0;
                w_sa = 5'd0;
                w_da = 5'd0;
            end
            default: begin
                w_sb   = 5'd0;
                w_sa   = 5'd0;
                w_da   = 5'd0;
                w_next = S_FETCH;
            end
        endcase
    end

    assign w_cw = {w_en_pc, w_en_mem, w_en_alu, w_pcsel, w_bsel, w_sl, w_wm, w_wr,
                   w_ps, w_fs, w_sb, w_sa, w_da};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
            r_ir    <= 32'd0;
        end else begin
            r_state <= w_next;
            if (r_state == S_FETCH) r_ir <= instruction;
        end
    end

    // Outputs are gated by reset so an aborted instruction never issues a write.
    assign control_word = reset ? w_cw : '0;
    assign constant     = reset ? w_const : 64'd0;
    assign state        = r_state;
    assign illegal      = (r_state == S_HALT);
endmodule

// File: tb/tb_legv8_control_fsm.sv
// Scoreboard bench for legv8_control_fsm: each driven cycle pushes its expected outputs, the negedge monitor pops and compares.
module tb_legv8_control_fsm;
    localparam int IW = 98;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] instruction;
    logic [4:0]  status;
    logic [29:0] control_word;
    logic [63:0] constant;
    logic [2:0]  state;
    logic        illegal;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [IW-1:0] exp_q[$];
    logic [IW-1:0] mon_e;
    string       cur_tag = "init";

    legv8_control_fsm dut (
        .clock(clock), .reset(reset), .instruction(instruction), .status(status),
        .control_word(control_word), .constant(constant), .state(state), .illegal(illegal)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [29:0] mk_cw(input logic en_pc, input logic en_mem, input logic en_alu,
                                          input logic pcsel, input logic bsel, input logic sl,
                                          input logic wm, input logic wr, input logic [1:0] ps,
                                          input logic [4:0] fs, input logic [4:0] sb,
                                          input logic [4:0] sa, input logic [4:0] da);
        return {en_pc, en_mem, en_alu, pcsel, bsel, sl, wm, wr, ps, fs, sb, sa, da};
    endfunction

    logic [29:0] cw_fetch;
    assign cw_fetch = mk_cw(0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 5'b00000, 5'd31, 5'd31, 5'd31);

    // one clock period of stimulus plus its expected outputs
    task automatic cycle(input string tag, input logic rst, input logic [31:0] ins, input logic [4:0] st,
                         input logic [2:0] e_state, input logic [29:0] e_cw,
                         input logic [63:0] e_const, input logic e_ill);
        @(posedge clock);
        #1;
        cur_tag     = tag;
        reset       = rst;
        instruction = ins;
        status      = st;
        exp_q.push_back({e_state, e_ill, e_const, e_cw});
    endtask

    task automatic fetch(input string tag, input logic [31:0] ins);
        cycle({tag, ".fetch"}, 1'b1, ins, 5'($urandom_range(0, 31)), 3'd0, cw_fetch, 64'd0, 1'b0);
    endtask

    task automatic step(input string tag, input logic [4:0] st, input logic [2:0] e_state,
                        input logic [29:0] e_cw, input logic [63:0] e_const, input logic e_ill);
        cycle(tag, 1'b1, $urandom, st, e_state, e_cw, e_const, e_ill);
    endtask

    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check({cur_tag, ".state"}, 64'(state), 64'(mon_e[97:95]));
            check({cur_tag, ".illegal"}, 64'(illegal), 64'(mon_e[94]));
            check({cur_tag, ".const"}, constant, mon_e[93:30]);
            check({cur_tag, ".cw"}, 64'(control_word), 64'(mon_e[29:0]));
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    logic [10:0] r_ops[4];
    logic [4:0]  r_fss[4];
    int          op;
    logic [4:0]  rm, rn, rd;

    initial begin
        reset       = 1'b0;
        instruction = 32'd0;
        status      = 5'd0;
        r_ops = '{11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000};
        r_fss = '{5'b01000, 5'b01001, 5'b00000, 5'b00100};

        for (int i = 0; i < 3; i++)
            cycle("reset", 1'b0, 32'h8B020023, 5'd0, 3'd0, 30'd0, 64'd0, 1'b0);

        fetch("add", 32'h8B020023);
        step("add.exec", 5'd0, 3'd1, mk_cw(0, 0, 1, 0, 0, 0, 0, 1, 2'b00, 5'b01000, 5'd2, 5'd1, 5'd3), 64'd0, 1'b0);

        fetch("ldur", 32'hF8408045);
        step("ldur.exec", 5'd0, 3'd1, mk_cw(0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 5'b01000, 5'd31, 5'd2, 5'd31), 64'd8, 1'b0);
        step("ldur.mem", 5'd0, 3'd2, mk_cw(0, 1, 0, 0, 1, 0, 0, 1, 2'b00, 5'b01000, 5'd31, 5'd2, 5'd5), 64'd8, 1'b0);

        fetch("cbz_t", {8'hB4, 19'h7FFFE, 5'd4});
        step("cbz_t.exec", 5'b00001, 3'd1, mk_cw(0, 0, 0, 1, 0, 0, 0, 0, 2'b11, 5'b00100, 5'd31, 5'd4, 5'd31), 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
        fetch("cbz_n", {8'hB4, 19'h7FFFE, 5'd4});
        step("cbz_n.exec", 5'b11110, 3'd1, mk_cw(0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 5'b00100, 5'd31, 5'd4, 5'd31), 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
        fetch("cbnz_t", {8'hB5, 19'd3, 5'd9});
        step("cbnz_t.exec", 5'b00000, 3'd1, mk_cw(0, 0, 0, 1, 0, 0, 0, 0, 2'b11, 5'b00100, 5'd31, 5'd9, 5'd31), 64'd2, 1'b0);

        fetch("subs", {11'b11101011000, 5'd3, 6'd0, 5'd2, 5'd1});
        step("subs.exec", 5'd0, 3'd1, mk_cw(0, 0, 1, 0, 0, 1, 0, 1, 2'b00, 5'b01001, 5'd3, 5'd2, 5'd1), 64'd0, 1'b0);
        fetch("addi", {10'b1001000100, 12'hABC, 5'd6, 5'd7});
        step("addi.exec", 5'd0, 3'd1, mk_cw(0, 0, 1, 0, 1, 0, 0, 1, 2'b00, 5'b01000, 5'd31, 5'd6, 5'd7), 64'h0ABC, 1'b0);
        fetch("subi", {10'b1101000100, 12'hFFF, 5'd9, 5'd8});
        step("subi.exec", 5'd0, 3'd1, mk_cw(0, 0, 1, 0, 1, 0, 0, 1, 2'b00, 5'b01001, 5'd31, 5'd9, 5'd8), 64'h0FFF, 1'b0);
        fetch("stur", {11'b11111000000, 9'h1FF, 2'b00, 5'd2, 5'd5});
        step("stur.exec", 5'd0, 3'd1, mk_cw(0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 5'b01000, 5'd5, 5'd2, 5'd31), 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        fetch("b_neg", {6'b000101, 26'h3FFFFFD});
        step("b_neg.exec", 5'd0, 3'd1, mk_cw(0, 0, 0, 1, 0, 0, 0, 0, 2'b11, 5'b00000, 5'd31, 5'd31, 5'd31), 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        fetch("b_max", {6'b000101, 26'h1FFFFFF});
        step("b_max.exec", 5'd0, 3'd1, mk_cw(0, 0, 0, 1, 0, 0, 0, 0, 2'b11, 5'b00000, 5'd31, 5'd31, 5'd31), 64'h1FF_FFFE, 1'b0);

        for (int i = 0; i < 8; i++) begin
            op = $urandom_range(0, 3);
            rm = 5'($urandom_range(0, 31));
            rn = 5'($urandom_range(0, 31));
            rd = 5'($urandom_range(0, 31));
            fetch("rnd", {r_ops[op], rm, 6'($urandom_range(0, 63)), rn, rd});
            step("rnd.exec", 5'($urandom_range(0, 31)), 3'd1,
                 mk_cw(0, 0, 1, 0, 0, 0, 0, 1, 2'b00, r_fss[op], rm, rn, rd), 64'd0, 1'b0);
        end

        fetch("abort", 32'h8B020023);
        cycle("abort.rst", 1'b0, 32'd0, 5'd0, 3'd0, 30'd0, 64'd0, 1'b0);
        fetch("post_abort", 32'hF8408045);
        step("post_abort.exec", 5'd0, 3'd1, mk_cw(0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 5'b01000, 5'd31, 5'd2, 5'd31), 64'd8, 1'b0);
        step("post_abort.mem", 5'd0, 3'd2, mk_cw(0, 1, 0, 0, 1, 0, 0, 1, 2'b00, 5'b01000, 5'd31, 5'd2, 5'd5), 64'd8, 1'b0);

        fetch("halt", 32'h0000_0000);
        step("halt.exec", 5'd0, 3'd1, 30'd0, 64'd0, 1'b0);
        for (int i = 0; i < 10; i++)
            step("halt.hold", 5'($urandom_range(0, 31)), 3'd3, 30'd0, 64'd0, 1'b1);
        cycle("halt.rst", 1'b0, 32'd0, 5'd0, 3'd0, 30'd0, 64'd0, 1'b0);

        fetch("bc_subs", {11'b11101011000, 5'd3, 6'd0, 5'd2, 5'd1});
        step("bc_subs.exec", 5'd0, 3'd1, mk_cw(0, 0, 1, 0, 0, 1, 0, 1, 2'b00, 5'b01001, 5'd3, 5'd2, 5'd1), 64'd0, 1'b0);
`ifdef LEGV8_CTRL_BCOND_EN
        fetch("blt_t", {8'h54, 19'd5, 1'b0, 4'hB});
        step("blt_t.exec", 5'b00100, 3'd1, mk_cw(0, 0, 0, 1, 0, 0, 0, 0, 2'b11, 5'b00000, 5'd31, 5'd31, 5'd31), 64'd4, 1'b0);
        fetch("blt_n", {8'h54, 19'd5, 1'b0, 4'hB});
        step("blt_n.exec", 5'b10100, 3'd1, mk_cw(0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 5'b00000, 5'd31, 5'd31, 5'd31), 64'd4, 1'b0);
        fetch("bal", {8'h54, 19'd5, 1'b0, 4'hE});
        step("bal.exec", 5'($urandom_range(0, 31)), 3'd1, mk_cw(0, 0, 0, 1, 0, 0, 0, 0, 2'b11, 5'b00000, 5'd31, 5'd31, 5'd31), 64'd4, 1'b0);
        fetch("bnv", {8'h54, 19'd5, 1'b0, 4'hF});
        step("bnv.exec", 5'($urandom_range(0, 31)), 3'd1, mk_cw(0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 5'b00000, 5'd31, 5'd31, 5'd31), 64'd4, 1'b0);
`else
        fetch("blt", {8'h54, 19'd5, 1'b0, 4'hB});
        step("blt.exec", 5'b00100, 3'd1, 30'd0, 64'd0, 1'b0);
        for (int i = 0; i < 2; i++)
            step("blt.halt", 5'd0, 3'd3, 30'd0, 64'd0, 1'b1);
        cycle("blt.rst", 1'b0, 32'd0, 5'd0, 3'd0, 30'd0, 64'd0, 1'b0);
`endif

        @(posedge clock);
        @(negedge clock);
        #1;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
